cfg_latch_loader: RTL and testbench



---
 rtl/cfg_latch_loader.sv | 156 +++++++++++++++
 tb/tb_cfg_latch_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_latch_loader.sv
// cfg_latch_loader: write-side sequencer for latch-based configuration rows.
// Each accepted word is driven onto one row (or all rows) with a
// setup / enable-pulse / hold sequence. The data bus stays stable from the
// setup cycle until the hold window has ended, so no transparent latch ever
// sees its input change while its enable is high.
module cfg_latch_loader #(
  parameter int DATA_W  = 32,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 4,
  parameter int PULSE_W = 2,
  parameter int HOLD_W  = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [ADDR_W-1:0] IN_ADDR,
  input  logic              IN_BCAST,
  input  logic [DATA_W-1:0] IN_DATA,
  output logic [DATA_W-1:0] LAT_D,
  output logic [ROWS-1:0]   LAT_EN,
  output logic              BUSY,
  output logic              ERR,
  input  logic              CLR_ERR
);

  // The counter must be able to hold the longer of the two timed phases.
  localparam int MAX_W = (PULSE_W > HOLD_W) ? PULSE_W : HOLD_W;
  localparam int CNT_W = $clog2(MAX_W + 1);

  // Counter loads are "cycles remaining after this one", so a phase of N
  // cycles leaves when the counter reads zero.
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_W - 1);

  // One extra bit so the compare also works when ROWS == 2**ADDR_W.
  localparam logic [ADDR_W:0] ROWS_LIMIT = (ADDR_W + 1)'(ROWS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] lat_d_reg, lat_d_next;
  logic [ROWS-1:0]   lat_en_reg, lat_en_next;
  logic [ROWS-1:0]   mask_reg, mask_next;
  logic              err_reg, err_next;

  logic [ROWS-1:0]   addr_onehot;
  logic              addr_in_range;

  // Row decoder: one compare per row; out-of-range addresses decode to zero.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_dec
    assign addr_onehot[gi] = (IN_ADDR == ADDR_W'(gi));
  end

  assign addr_in_range = ({1'b0, IN_ADDR} < ROWS_LIMIT);

  // Handshake-side status is a pure decode of the state register.
  assign IN_READY = (state_reg == IDLE);
  assign BUSY     = (state_reg != IDLE);

  assign LAT_D  = lat_d_reg;
  assign LAT_EN = lat_en_reg;
  assign ERR    = err_reg;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and next-datapath decode; enables default low every cycle.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    lat_d_next  = lat_d_reg;
    lat_en_next = '0;
    mask_next   = mask_reg;
    err_next    = err_reg;

    // Clear first so that a same-cycle error below takes priority.
    if (CLR_ERR) begin
      err_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (IN_VALID) begin
          if (IN_BCAST || addr_in_range) begin
            lat_d_next = IN_DATA;
            mask_next  = IN_BCAST ? {ROWS{1'b1}} : addr_onehot;
            state_next = SETUP;
          end else begin
            // Request is consumed; nothing reaches the latch rows.
            err_next = 1'b1;
          end
        end
      end

      SETUP: begin
        // Data has been stable for a full cycle; raise the enables next.
        state_next  = PULSE;
        cnt_next    = PULSE_LOAD;
        lat_en_next = mask_reg;
      end

      PULSE: begin
        if (cnt_reg == '0) begin
          state_next = HOLD;
          cnt_next   = HOLD_LOAD;
        end else begin
          cnt_next    = cnt_reg - 1'b1;
          lat_en_next = mask_reg;
        end
      end

      HOLD: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath registers; reset drops the enables immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt_reg    <= '0;
      lat_d_reg  <= '0;
      lat_en_reg <= '0;
      mask_reg   <= '0;
      err_reg    <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      lat_d_reg  <= lat_d_next;
      lat_en_reg <= lat_en_next;
      mask_reg   <= mask_next;
      err_reg    <= err_next;
    end
  end

endmodule

// File: tb/tb_cfg_latch_loader.sv
// Bench for cfg_latch_loader: a table-driven cycle sequence on the default
// configuration, plus hand-written sequences for the error path, reset in
// mid-pulse and a PULSE_W=1 / HOLD_W=3 build.
module tb_cfg_latch_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DUT a: defaults
  logic        a_rst, a_valid, a_ready, a_bcast, a_busy, a_err, a_clr;
  logic [3:0]  a_addr;
  logic [31:0] a_data, a_d;
  logic [15:0] a_en;

  // DUT b: ROWS=12 for the error path
  logic        b_rst, b_valid, b_ready, b_bcast, b_busy, b_err, b_clr;
  logic [3:0]  b_addr;
  logic [31:0] b_data, b_d;
  logic [11:0] b_en;

  // DUT c: PULSE_W=1, HOLD_W=3
  logic        c_rst, c_valid, c_ready, c_bcast, c_busy, c_err, c_clr;
  logic [3:0]  c_addr;
  logic [31:0] c_data, c_d;
  logic [15:0] c_en;

  cfg_latch_loader #(.DATA_W(32), .ROWS(16), .ADDR_W(4), .PULSE_W(2), .HOLD_W(1)) u_a (
    .CLK(clk), .RST(a_rst), .IN_VALID(a_valid), .IN_READY(a_ready), .IN_ADDR(a_addr),
    .IN_BCAST(a_bcast), .IN_DATA(a_data), .LAT_D(a_d), .LAT_EN(a_en), .BUSY(a_busy),
    .ERR(a_err), .CLR_ERR(a_clr));

  cfg_latch_loader #(.DATA_W(32), .ROWS(12), .ADDR_W(4), .PULSE_W(2), .HOLD_W(1)) u_b (
    .CLK(clk), .RST(b_rst), .IN_VALID(b_valid), .IN_READY(b_ready), .IN_ADDR(b_addr),
    .IN_BCAST(b_bcast), .IN_DATA(b_data), .LAT_D(b_d), .LAT_EN(b_en), .BUSY(b_busy),
    .ERR(b_err), .CLR_ERR(b_clr));

  cfg_latch_loader #(.DATA_W(32), .ROWS(16), .ADDR_W(4), .PULSE_W(1), .HOLD_W(3)) u_c (
    .CLK(clk), .RST(c_rst), .IN_VALID(c_valid), .IN_READY(c_ready), .IN_ADDR(c_addr),
    .IN_BCAST(c_bcast), .IN_DATA(c_data), .LAT_D(c_d), .LAT_EN(c_en), .BUSY(c_busy),
    .ERR(c_err), .CLR_ERR(c_clr));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        valid;
    logic        bcast;
    logic [3:0]  addr;
    logic [31:0] data;
    logic        ready;
    logic        busy;
    logic [15:0] en;
    logic [31:0] d;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic b, input logic [3:0] ad,
                              input logic [31:0] dat, input logic rdy, input logic bsy,
                              input logic [15:0] en, input logic [31:0] d);
    vec_t r;
    r.valid = v; r.bcast = b; r.addr = ad; r.data = dat;
    r.ready = rdy; r.busy = bsy; r.en = en; r.d = d;
    return r;
  endfunction

  localparam int NV = 26;
  vec_t        tbl [NV];
  logic [31:0] latch [16];
  logic [15:0] prev_en;
  logic [31:0] prev_d;
  logic [15:0] exp_en [7];
  logic        exp_rdy [7];

  initial begin
    // Each row: inputs presented during the cycle, outputs expected in it.
    // Single write, addr 3
    tbl[0]  = mk(1'b1, 1'b0, 4'd3, 32'hA5A5_0F0F, 1'b1, 1'b0, 16'h0000, 32'h0);
    tbl[1]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'hA5A5_0F0F);
    tbl[2]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0008, 32'hA5A5_0F0F);
    tbl[3]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0008, 32'hA5A5_0F0F);
    tbl[4]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'hA5A5_0F0F);
    // Broadcast (address ignored)
    tbl[5]  = mk(1'b1, 1'b1, 4'd7, 32'h1234_5678, 1'b1, 1'b0, 16'h0000, 32'hA5A5_0F0F);
    tbl[6]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'h1234_5678);
    tbl[7]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'hFFFF, 32'h1234_5678);
    tbl[8]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'hFFFF, 32'h1234_5678);
    tbl[9]  = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'h1234_5678);
    // Back-to-back with IN_VALID held: addr 0, 1, 2
    tbl[10] = mk(1'b1, 1'b0, 4'd0, 32'h0000_AAA0, 1'b1, 1'b0, 16'h0000, 32'h1234_5678);
    tbl[11] = mk(1'b1, 1'b0, 4'd1, 32'h0000_BBB1, 1'b0, 1'b1, 16'h0000, 32'h0000_AAA0);
    tbl[12] = mk(1'b1, 1'b0, 4'd1, 32'h0000_BBB1, 1'b0, 1'b1, 16'h0001, 32'h0000_AAA0);
    tbl[13] = mk(1'b1, 1'b0, 4'd1, 32'h0000_BBB1, 1'b0, 1'b1, 16'h0001, 32'h0000_AAA0);
    tbl[14] = mk(1'b1, 1'b0, 4'd1, 32'h0000_BBB1, 1'b0, 1'b1, 16'h0000, 32'h0000_AAA0);
    tbl[15] = mk(1'b1, 1'b0, 4'd1, 32'h0000_BBB1, 1'b1, 1'b0, 16'h0000, 32'h0000_AAA0);
    tbl[16] = mk(1'b1, 1'b0, 4'd2, 32'h0000_CCC2, 1'b0, 1'b1, 16'h0000, 32'h0000_BBB1);
    tbl[17] = mk(1'b1, 1'b0, 4'd2, 32'h0000_CCC2, 1'b0, 1'b1, 16'h0002, 32'h0000_BBB1);
    tbl[18] = mk(1'b1, 1'b0, 4'd2, 32'h0000_CCC2, 1'b0, 1'b1, 16'h0002, 32'h0000_BBB1);
    tbl[19] = mk(1'b1, 1'b0, 4'd2, 32'h0000_CCC2, 1'b0, 1'b1, 16'h0000, 32'h0000_BBB1);
    tbl[20] = mk(1'b1, 1'b0, 4'd2, 32'h0000_CCC2, 1'b1, 1'b0, 16'h0000, 32'h0000_BBB1);
    tbl[21] = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'h0000_CCC2);
    tbl[22] = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0004, 32'h0000_CCC2);
    tbl[23] = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0004, 32'h0000_CCC2);
    tbl[24] = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b0, 1'b1, 16'h0000, 32'h0000_CCC2);
    tbl[25] = mk(1'b0, 1'b0, 4'd0, 32'h0,         1'b1, 1'b0, 16'h0000, 32'h0000_CCC2);

    for (int r = 0; r < 16; r++) latch[r] = 32'h0;

    a_rst = 1'b1; a_valid = 1'b0; a_bcast = 1'b0; a_addr = 4'd0; a_data = 32'h0; a_clr = 1'b0;
    b_rst = 1'b1; b_valid = 1'b0; b_bcast = 1'b0; b_addr = 4'd0; b_data = 32'h0; b_clr = 1'b0;
    c_rst = 1'b1; c_valid = 1'b0; c_bcast = 1'b0; c_addr = 4'd0; c_data = 32'h0; c_clr = 1'b0;

    // Reset state
    @(negedge clk);
    chk("reset ready", 32'(a_ready), 32'd1);
    chk("reset busy",  32'(a_busy),  32'd0);
    chk("reset en",    32'(a_en),    32'd0);
    chk("reset d",     a_d,          32'd0);
    chk("reset err",   32'(a_err),   32'd0);
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;

    // Table phase on DUT a, with a behavioural latch model and stability monitor
    @(posedge clk); #1;
    prev_en = 16'h0;
    prev_d  = a_d;
    for (int i = 0; i < NV; i++) begin
      a_valid = tbl[i].valid; a_bcast = tbl[i].bcast;
      a_addr  = tbl[i].addr;  a_data  = tbl[i].data;
      @(negedge clk);
      chk($sformatf("row%0d ready", i), 32'(a_ready), 32'(tbl[i].ready));
      chk($sformatf("row%0d busy", i),  32'(a_busy),  32'(tbl[i].busy));
      chk($sformatf("row%0d en", i),    32'(a_en),    32'(tbl[i].en));
      chk($sformatf("row%0d d", i),     a_d,          tbl[i].d);
      chk($sformatf("row%0d err", i),   32'(a_err),   32'd0);
      if (a_en != 16'h0 || prev_en != 16'h0)
        chk($sformatf("row%0d d stable", i), a_d, prev_d);
      chk($sformatf("row%0d en shape", i),
          32'((a_en == 16'h0) || $onehot(a_en) || (a_en == 16'hFFFF)), 32'd1);
      for (int r = 0; r < 16; r++)
        if (a_en[r]) latch[r] = a_d;
      prev_en = a_en;
      prev_d  = a_d;
      if (i == 9)
        for (int r = 0; r < 16; r++)
          chk($sformatf("bcast latch%0d", r), latch[r], 32'h1234_5678);
      @(posedge clk); #1;
    end
    a_valid = 1'b0;
    chk("latch0",  latch[0],  32'h0000_AAA0);
    chk("latch1",  latch[1],  32'h0000_BBB1);
    chk("latch2",  latch[2],  32'h0000_CCC2);
    chk("latch3",  latch[3],  32'h1234_5678);
    chk("latch15", latch[15], 32'h1234_5678);

    // Reset during the second PULSE cycle
    a_valid = 1'b1; a_addr = 4'd5; a_data = 32'hCAFE_BABE;
    @(posedge clk); #1;            // cycle 1 (SETUP)
    a_valid = 1'b0;
    @(posedge clk); #1;            // cycle 2 (PULSE 1)
    chk("rst pulse1 en", 32'(a_en), 32'h0020);
    @(posedge clk); #1;            // cycle 3 (PULSE 2)
    chk("rst pulse2 en", 32'(a_en), 32'h0020);
    a_rst = 1'b1;
    #1;
    chk("async rst en",    32'(a_en),    32'd0);
    chk("async rst d",     a_d,          32'd0);
    chk("async rst ready", 32'(a_ready), 32'd1);
    chk("async rst busy",  32'(a_busy),  32'd0);
    @(negedge clk);
    a_rst = 1'b0;

    // First write after release has full timing
    exp_en[0] = 16'h0; exp_en[1] = 16'h0; exp_en[2] = 16'h0040;
    exp_en[3] = 16'h0040; exp_en[4] = 16'h0; exp_en[5] = 16'h0;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0;
    exp_rdy[3] = 1'b0; exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b1;
    @(posedge clk); #1;
    a_valid = 1'b1; a_addr = 4'd6; a_data = 32'h0BAD_F00D;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("post-rst c%0d en", k),    32'(a_en),    32'(exp_en[k]));
      chk($sformatf("post-rst c%0d ready", k), 32'(a_ready), 32'(exp_rdy[k]));
      if (k > 0) chk($sformatf("post-rst c%0d d", k), a_d, 32'h0BAD_F00D);
      @(posedge clk); #1;
      a_valid = 1'b0;
    end

    // Error path on DUT b (ROWS=12)
    b_valid = 1'b1; b_addr = 4'd13; b_data = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("err set",       32'(b_err),   32'd1);
    chk("err ready",     32'(b_ready), 32'd1);
    chk("err busy",      32'(b_busy),  32'd0);
    chk("err en",        32'(b_en),    32'd0);
    chk("err d",         b_d,          32'd0);
    @(posedge clk); #1;
    b_valid = 1'b1; b_addr = 4'd14; b_clr = 1'b1;
    @(posedge clk); #1;
    b_valid = 1'b0; b_clr = 1'b0;
    @(negedge clk);
    chk("err set beats clr", 32'(b_err), 32'd1);
    chk("err2 en",           32'(b_en),  32'd0);
    @(posedge clk); #1;
    b_clr = 1'b1;
    @(posedge clk); #1;
    b_clr = 1'b0;
    @(negedge clk);
    chk("err cleared", 32'(b_err), 32'd0);
    // Highest in-range row is accepted normally
    @(posedge clk); #1;
    b_valid = 1'b1; b_addr = 4'd11; b_data = 32'h0000_0077;
    @(posedge clk); #1;
    b_valid = 1'b0;
    @(negedge clk);
    chk("row11 busy", 32'(b_busy), 32'd1);
    chk("row11 d",    b_d,         32'h0000_0077);
    @(posedge clk); #1;
    @(negedge clk);
    chk("row11 en",   32'(b_en),   32'h0800);
    chk("row11 err",  32'(b_err),  32'd0);

    // PULSE_W=1, HOLD_W=3 on DUT c: one enable cycle, 6-cycle period
    exp_en[0] = 16'h0; exp_en[1] = 16'h0; exp_en[2] = 16'h0200; exp_en[3] = 16'h0;
    exp_en[4] = 16'h0; exp_en[5] = 16'h0; exp_en[6] = 16'h0;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b0; exp_rdy[3] = 1'b0;
    exp_rdy[4] = 1'b0; exp_rdy[5] = 1'b0; exp_rdy[6] = 1'b1;
    @(posedge clk); #1;
    c_valid = 1'b1; c_addr = 4'd9; c_data = 32'h0000_0005;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("p1h3 c%0d en", k),    32'(c_en),    32'(exp_en[k]));
      chk($sformatf("p1h3 c%0d ready", k), 32'(c_ready), 32'(exp_rdy[k]));
      @(posedge clk); #1;
      c_valid = 1'b0;
    end
    chk("p1h3 d", c_d, 32'h0000_0005);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
